// File: rtl/inst_buffer.sv
// Instruction buffer: 2-in / 2-out FIFO between fetch and the dual decoder slots, one-cycle flush.
// Latency: an entry pushed at edge N is visible on out_* after that edge; no same-cycle bypass.
// Backpressure: fetch_ready only when two entries are free; decoders pop in order via dec_ready.
module inst_buffer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [31:0]      in_pc0,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst0,
    input  logic [31:0]      in_inst1,
    input  logic [7:0]       in_exc0,
    input  logic [7:0]       in_exc1,
    output logic             fetch_ready,
    input  logic [1:0]       dec_ready,
    output logic [1:0]       out_valid,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_inst1,
    output logic [7:0]       out_exc0,
    output logic [7:0]       out_exc1,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [7:0]  exc;
    } entry_t;

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO  = (PTR_W+1)'(2);
    localparam logic [PTR_W:0]   CNT_PUSH = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic [PTR_W-1:0] rd1, wr1;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic             pop0, pop1;
    logic             wr0_en, wr1_en;
    entry_t           head0, head1;

    assign count       = count_q;
    // Two free slots are required so a full pair never has to be split.
    assign fetch_ready = (count_q <= CNT_PUSH);
    assign out_valid   = {(count_q >= CNT_TWO), (count_q >= CNT_ONE)};

    assign rd1   = rd_q + PTR_ONE;
    assign wr1   = wr_q + PTR_ONE;
    assign head0 = mem_q[rd_q];
    assign head1 = mem_q[rd1];

    always_comb begin
        push_n = 2'd0;
        if (fetch_ready && in_valid[0]) begin
            push_n = in_valid[1] ? 2'd2 : 2'd1;
        end

        pop0  = out_valid[0] & dec_ready[0];
        pop1  = pop0 & out_valid[1] & dec_ready[1];
        pop_n = {1'b0, pop0} + {1'b0, pop1};

        wr0_en = !rst && !flush && (push_n != 2'd0);
        wr1_en = !rst && !flush && (push_n == 2'd2);

        rd_d    = rd_q + PTR_W'(pop_n);
        wr_d    = wr_q + PTR_W'(push_n);
        count_d = count_q + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        if (rst || flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        count_q <= count_d;
    end

    always_ff @(posedge clk) begin
        if (wr0_en) begin
            mem_q[wr_q] <= '{pc: in_pc0, inst: in_inst0, exc: in_exc0};
        end
        if (wr1_en) begin
            mem_q[wr1] <= '{pc: in_pc1, inst: in_inst1, exc: in_exc1};
        end
    end

    always_comb begin
        out_pc0   = '0;
        out_inst0 = '0;
        out_exc0  = '0;
        out_pc1   = '0;
        out_inst1 = '0;
        out_exc1  = '0;
        if (out_valid[0]) begin
            out_pc0   = head0.pc;
            out_inst0 = head0.inst;
            out_exc0  = head0.exc;
        end
        if (out_valid[1]) begin
            out_pc1   = head1.pc;
            out_inst1 = head1.inst;
            out_exc1  = head1.exc;
        end
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Decoupling FIFO between the fetch stage and the dual decoder slots (2R/3R/imm decoders).
- Accepts up to 2 fetched instructions per cycle, each with PC and pre-decode fetch-exception tag.
- Presents the two oldest entries to decoder slots 0/1 and retires up to 2 per cycle.
- Flush on branch mispredict or exception redirect empties it in one cycle.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- PTR_W, 4, log2(DEPTH); count width is PTR_W+1.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all entries and any push/pop this cycle
- in_valid  in  2  per-slot fetch valid; bit1 honoured only when bit0=1
- in_pc0 / in_pc1  in  32 each  PC of fetch slot 0/1
- in_inst0 / in_inst1  in  32 each  instruction word of fetch slot 0/1
- in_exc0 / in_exc1  in  8 each  {exc_valid, exc_cause[6:0]} fetch exception tag (e.g. ADEF, TLB refill)
- fetch_ready  out  1  1 when at least 2 entries are free
- dec_ready  in  2  decoder slot 0/1 can consume; bit1 honoured only when bit0 pops
- out_valid  out  2  bit0: count>=1; bit1: count>=2
- out_pc0 / out_pc1  out  32 each  PC of head / head+1 entry
- out_inst0 / out_inst1  out  32 each  instruction of head / head+1
- out_exc0 / out_exc1  out  8 each  exception tag of head / head+1
- count  out  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of 72 bits {pc, inst, exc}. Head pointer (rd), tail pointer (wr), occupancy count; pointers wrap modulo DEPTH.
- Push:
  - push_n = 0/1/2 = fetch_ready & in_valid[0] ? (in_valid[1] ? 2 : 1) : 0.
  - Slot0 is written at wr and slot1 at wr+1 (mod DEPTH).
  - wr advances by push_n.
  - in_valid=2'b10 pushes nothing.
- Pop:
  - pop0 = out_valid[0] & dec_ready[0].
  - pop1 = pop0 & out_valid[1] & dec_ready[1].
  - pop_n = pop0 + pop1; rd advances by pop_n.
  - A slot-1 pop without a slot-0 pop is never allowed; order is strictly preserved.
- Next state: count_next = count + push_n - pop_n. Simultaneous push and pop in the same cycle are both performed.
- Outputs:
  - out_* are combinational reads at rd and rd+1 (mod DEPTH).
  - An entry pushed in cycle N is first visible on out_* in cycle N+1. There is no same-cycle bypass.
  - out_pc/inst/exc of a slot are driven to 0 when that slot's out_valid=0.
- fetch_ready = (DEPTH - count) >= 2. It is combinational from count only and never depends on this cycle's pops.
  - At count = DEPTH-1, fetch_ready = 0 even though one slot is free.
- Flush, highest priority:
  - rd, wr and count go to 0 at the next edge.
  - Push and pop in the flush cycle have no effect.
  - out_valid=0 from the following cycle.
  - Flush while empty or full has the same effect.
- Reset (rst=1 at an edge): rd=0, wr=0, count=0.
  - Therefore out_valid=2'b00, fetch_ready=1, and all out_* data are 0.
  - Entry storage need not be reset.
  - Reset asserted mid-stream behaves identically to flush and also overrides push and pop.
- Exception tags pass through unmodified. The buffer does not interpret exc_valid; the decoder merges it with its own INE cause.
- No overflow or underflow is possible by construction. A bench assertion must still check 0 <= count <= DEPTH every cycle.

Test Plan:
- Reset, then push in_valid=11 with pc 0x1c000000/0x1c000004, dec_ready=00 -> next cycle count=2, out_valid=11, out_pc0=0x1c000000, out_pc1=0x1c000004.
- Fill: push pairs with dec_ready=00 until count=16 -> fetch_ready=0 at count 15 and 16. An extra in_valid=11 is ignored and count stays 16.
- Steady state at count=4: in_valid=11 and dec_ready=11 every cycle -> count stays 4, output order equals PC order, wr/rd wrap past 15 without loss.
- dec_ready=10 at count=3 -> no pop, count unchanged. dec_ready=01 -> pop exactly 1 and out_pc0 becomes the old out_pc1.
- Flush together with in_valid=11 and dec_ready=11 at count=9 -> next cycle count=0, out_valid=00, fetch_ready=1.
- in_exc0=0x80|cause with pc 0x1c000010 -> out_exc0 shows the same 8-bit value alongside out_pc0=0x1c000010, one cycle later.
